// File: rtl/framebuffer_fill.sv
// Single-port-write / single-port-read frame buffer with a power-on clear and a fill engine.
// Define FB_FILL_RECT_EN for rectangle fills; without it every fill covers the whole frame.
module framebuffer_fill #(
    parameter int FRAME_WIDTH    = 640,
    parameter int FRAME_HEIGHT   = 480,
    parameter int SCALING_FACTOR = 1,
    parameter int ADDR_WIDTH     = 19,
    parameter int DATA_WIDTH     = 8,
    parameter int X_WIDTH        = 10,
    parameter int Y_WIDTH        = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fill_start,
    input  logic [DATA_WIDTH-1:0] fill_colour,
    input  logic [X_WIDTH-1:0]    fill_x0,
    input  logic [X_WIDTH-1:0]    fill_x1,
    input  logic [Y_WIDTH-1:0]    fill_y0,
    input  logic [Y_WIDTH-1:0]    fill_y1,
    output logic                  fill_busy,
    output logic                  fill_done,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int W          = FRAME_WIDTH / SCALING_FACTOR;
    localparam int H          = FRAME_HEIGHT / SCALING_FACTOR;
    localparam int NUM_PIXELS = W * H;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(NUM_PIXELS - 1);
    localparam logic [ADDR_WIDTH:0]   PIXEL_LIMIT = (ADDR_WIDTH + 1)'(NUM_PIXELS);

    typedef enum logic [1:0] {CLEAR, IDLE, FILL, DONE} state_e;

    logic [DATA_WIDTH-1:0] mem [NUM_PIXELS];

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] colour_q, colour_d;
    logic                  busy_q, done_q, ready_q;

    logic                  memWe;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [DATA_WIDTH-1:0] memData;
    logic                  userWrite;

`ifdef FB_FILL_RECT_EN
    localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(W);
    localparam logic [X_WIDTH-1:0]    X_MAX      = X_WIDTH'(W - 1);
    localparam logic [Y_WIDTH-1:0]    Y_MAX      = Y_WIDTH'(H - 1);

    logic [X_WIDTH-1:0]    x_q, x_d, x0_q, x0_d, x1_q, x1_d;
    logic [Y_WIDTH-1:0]    y_q, y_d, y1_q, y1_d;
    logic [ADDR_WIDTH-1:0] rowBase_q, rowBase_d;
    logic [X_WIDTH-1:0]    clampX1;
    logic [Y_WIDTH-1:0]    clampY1;
    logic                  emptyRect;

    assign clampX1   = (fill_x1 > X_MAX) ? X_MAX : fill_x1;
    assign clampY1   = (fill_y1 > Y_MAX) ? Y_MAX : fill_y1;
    assign emptyRect = (fill_x0 > clampX1) || (fill_y0 > clampY1);
`else
    logic unusedCoords;
    assign unusedCoords = ^{fill_x0, fill_x1, fill_y0, fill_y1};
`endif

    assign userWrite = wr_en && ({1'b0, wr_addr} < PIXEL_LIMIT);

    // Next-state and write-port selection; the clear counter doubles as the full-frame fill counter.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        colour_d = colour_q;
        memWe    = 1'b0;
        memAddr  = addr_q;
        memData  = '0;
`ifdef FB_FILL_RECT_EN
        x_d       = x_q;
        x0_d      = x0_q;
        x1_d      = x1_q;
        y_d       = y_q;
        y1_d      = y1_q;
        rowBase_d = rowBase_q;
`endif
        case (state_q)
            CLEAR: begin
                memWe = 1'b1;
                if (addr_q == LAST_ADDR) state_d = DONE;
                else                     addr_d  = addr_q + ADDR_WIDTH'(1);
            end
            IDLE: begin
                if (userWrite) begin
                    memWe   = 1'b1;
                    memAddr = wr_addr;
                    memData = wr_data;
                end
                if (fill_start) begin
                    colour_d = fill_colour;
`ifdef FB_FILL_RECT_EN
                    x_d       = fill_x0;
                    x0_d      = fill_x0;
                    x1_d      = clampX1;
                    y_d       = fill_y0;
                    y1_d      = clampY1;
                    rowBase_d = ADDR_WIDTH'(fill_y0) * ROW_STRIDE;
                    state_d   = emptyRect ? DONE : FILL;
`else
                    addr_d  = '0;
                    state_d = FILL;
`endif
                end
            end
            FILL: begin
                memWe   = 1'b1;
                memData = colour_q;
`ifdef FB_FILL_RECT_EN
                // Row base steps by the stride so the per-pixel address is a single add.
                memAddr = rowBase_q + ADDR_WIDTH'(x_q);
                if (x_q == x1_q) begin
                    if (y_q == y1_q) begin
                        state_d = DONE;
                    end else begin
                        x_d       = x0_q;
                        y_d       = y_q + Y_WIDTH'(1);
                        rowBase_d = rowBase_q + ROW_STRIDE;
                    end
                end else begin
                    x_d = x_q + X_WIDTH'(1);
                end
`else
                if (addr_q == LAST_ADDR) state_d = DONE;
                else                     addr_d  = addr_q + ADDR_WIDTH'(1);
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CLEAR;
            addr_q   <= '0;
            colour_q <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
`ifdef FB_FILL_RECT_EN
            x_q       <= '0;
            x0_q      <= '0;
            x1_q      <= '0;
            y_q       <= '0;
            y1_q      <= '0;
            rowBase_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            colour_q <= colour_d;
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_d == DONE);
            ready_q  <= (state_d == IDLE);
`ifdef FB_FILL_RECT_EN
            x_q       <= x_d;
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            y_q       <= y_d;
            y1_q      <= y1_d;
            rowBase_q <= rowBase_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && memWe) mem[memAddr] <= memData;
    end

    // Read returns pre-write contents on a same-address collision.
    always_ff @(posedge clk) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= ({1'b0, rd_addr} < PIXEL_LIMIT) ? mem[rd_addr] : '0;
    end

    assign fill_busy = busy_q;
    assign fill_done = done_q;
    assign wr_ready  = ready_q;

endmodule
